// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 4-bit-opcode MIPS-style datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback with a memory-wait watchdog.
`timescale 1ns/1ps
module multicycle_control #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TW      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       ir_wr,
    output logic       iord,
    output logic       memrd,
    output logic       memwr,
    output logic       memtoreg,
    output logic       regdes,
    output logic       regwr,
    output logic       alusrc_a,
    output logic [1:0] alusrc_b,
    output logic [1:0] aluop,
    output logic [3:0] state,
    output logic       trap,
    output logic [1:0] trap_cause
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        R_WB     = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        TRAP     = 4'd15
    } state_t;

    localparam logic [3:0] OP_SLT   = 4'b0100;
    localparam logic [3:0] OP_LOAD  = 4'b0101;
    localparam logic [3:0] OP_STORE = 4'b0110;
    localparam logic [3:0] OP_BEQ   = 4'b0111;
    localparam logic [3:0] OP_JUMP  = 4'b1000;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    state_t          state_q, state_d;
    logic [TW-1:0]   wd_q, wd_d;
    logic            trap_q, trap_d;
    logic [1:0]      cause_q, cause_d;
    logic            mem_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wd_q    <= '0;
            trap_q  <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        trap_d   = trap_q;
        cause_d  = cause_q;
        wd_d     = wd_q;
        mem_wait = 1'b0;
        pc_wr    = 1'b0;
        pc_src   = 2'b00;
        ir_wr    = 1'b0;
        iord     = 1'b0;
        memrd    = 1'b0;
        memwr    = 1'b0;
        memtoreg = 1'b0;
        regdes   = 1'b0;
        regwr    = 1'b0;
        alusrc_a = 1'b0;
        alusrc_b = 2'b00;
        aluop    = 2'b00;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                memrd    = 1'b1;
                alusrc_b = 2'b01;
                if (mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = DECODE;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            DECODE: begin
                alusrc_b = 2'b11;
                if (opcode <= OP_SLT) begin
                    state_d = EXEC_R;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = MEM_ADDR;
                end else if (opcode == OP_BEQ) begin
                    state_d = BRANCH;
                end else if (opcode == OP_JUMP) begin
                    state_d = JUMP;
                end else begin
                    state_d = TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            EXEC_R: begin
                alusrc_a = 1'b1;
                aluop    = 2'b10;
                state_d  = R_WB;
            end
            R_WB: begin
                regdes  = 1'b1;
                regwr   = 1'b1;
                state_d = FETCH;
            end
            MEM_ADDR: begin
                alusrc_a = 1'b1;
                alusrc_b = 2'b10;
                state_d  = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                iord  = 1'b1;
                memrd = 1'b1;
                if (mem_ready) state_d = MEM_WB;
                else           mem_wait = 1'b1;
            end
            MEM_WB: begin
                memtoreg = 1'b1;
                regwr    = 1'b1;
                state_d  = FETCH;
            end
            MEM_WR: begin
                iord  = 1'b1;
                memwr = 1'b1;
                if (mem_ready) state_d = FETCH;
                else           mem_wait = 1'b1;
            end
            BRANCH: begin
                alusrc_a = 1'b1;
                aluop    = 2'b01;
                pc_src   = 2'b01;
                pc_wr    = zero;
                state_d  = FETCH;
            end
            JUMP: begin
                pc_src  = 2'b10;
                pc_wr   = 1'b1;
                state_d = FETCH;
            end
            TRAP: state_d = TRAP;
            default: begin
                state_d = TRAP;
                trap_d  = 1'b1;
                cause_d = CAUSE_ILLEGAL;
            end
        endcase

        // The wait cycle that would bring the counter to TIMEOUT traps unless mem_ready is high.
        if (mem_wait) begin
            wd_d = wd_q + 1'b1;
            if (TIMEOUT != 0 && wd_q == TW'(TIMEOUT - 1)) begin
                state_d = TRAP;
                trap_d  = 1'b1;
                cause_d = CAUSE_TIMEOUT;
            end
        end
        if (state_d != state_q) wd_d = '0;
    end

    assign state      = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_wr, ir_wr, iord, memrd, memwr, memtoreg, regdes, regwr, alusrc_a, trap;
    logic [1:0] pc_src, alusrc_b, aluop, trap_cause;
    logic [3:0] state;

    multicycle_control #(.TIMEOUT(15), .TW(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr), .iord(iord), .memrd(memrd),
        .memwr(memwr), .memtoreg(memtoreg), .regdes(regdes), .regwr(regwr),
        .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop), .state(state),
        .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] S_IDLE = 4'd0,  S_F  = 4'd1,  S_D   = 4'd2,  S_EX = 4'd3;
    localparam logic [3:0] S_RWB  = 4'd4,  S_MA = 4'd5,  S_MRD = 4'd6,  S_MWB = 4'd7;
    localparam logic [3:0] S_MWR  = 4'd8,  S_BR = 4'd9,  S_J   = 4'd10, S_TRAP = 4'd15;
    localparam logic [3:0] OP_ADD = 4'b0010, OP_LD = 4'b0101, OP_ST = 4'b0110;
    localparam logic [3:0] OP_BEQ = 4'b0111, OP_JMP = 4'b1000, OP_BAD = 4'b1011;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       ir_wr, iord, memrd, memwr, memtoreg, regdes, regwr, alusrc_a;
        logic [1:0] alusrc_b, aluop;
        logic       trap;
        logic [1:0] trap_cause;
    } ov_t;

    typedef struct {
        ov_t v;
        int  tag;
    } exp_t;

    exp_t       q[$];
    int         tag_n = 0;
    int         total = 0;
    int         bad = 0;
    logic [1:0] exp_cause = 2'b00;

    function automatic ov_t outs(input logic [3:0] st, input logic mr, input logic z,
                                 input logic [1:0] cause);
        ov_t o;
        o = '0;
        o.state = st;
        case (st)
            S_F:    begin o.memrd = 1'b1; o.alusrc_b = 2'b01; o.ir_wr = mr; o.pc_wr = mr; end
            S_D:    o.alusrc_b = 2'b11;
            S_EX:   begin o.alusrc_a = 1'b1; o.aluop = 2'b10; end
            S_RWB:  begin o.regdes = 1'b1; o.regwr = 1'b1; end
            S_MA:   begin o.alusrc_a = 1'b1; o.alusrc_b = 2'b10; end
            S_MRD:  begin o.iord = 1'b1; o.memrd = 1'b1; end
            S_MWB:  begin o.memtoreg = 1'b1; o.regwr = 1'b1; end
            S_MWR:  begin o.iord = 1'b1; o.memwr = 1'b1; end
            S_BR:   begin o.alusrc_a = 1'b1; o.aluop = 2'b01; o.pc_src = 2'b01; o.pc_wr = z; end
            S_J:    begin o.pc_src = 2'b10; o.pc_wr = 1'b1; end
            S_TRAP: begin o.trap = 1'b1; o.trap_cause = cause; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic push_exp(input logic [3:0] st, input logic mr, input logic z);
        exp_t e;
        e.v   = outs(st, mr, z, exp_cause);
        e.tag = tag_n;
        tag_n++;
        q.push_back(e);
    endtask

    task automatic step(input logic [3:0] st, input logic mr, input logic z, input logic [3:0] op);
        @(posedge clk);
        #1;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        push_exp(st, mr, z);
    endtask

    task automatic rst_cycles();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mem_ready = 1'b0;
        zero = 1'b0;
        opcode = 4'd0;
        exp_cause = 2'b00;
        push_exp(S_IDLE, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(S_IDLE, 1'b0, 1'b0);
    endtask

    task automatic check1(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    initial begin
        exp_t e;
        ov_t  act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {state, pc_wr, pc_src, ir_wr, iord, memrd, memwr, memtoreg, regdes,
                       regwr, alusrc_a, alusrc_b, aluop, trap, trap_cause};
                total++;
                if (act !== e.v) begin
                    bad++;
                    $display("FAIL step%0d outputs got=%h want=%h (state got=%0d want=%0d)",
                             e.tag, act, e.v, act.state, e.v.state);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL bench_timeout got=running want=finished");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        rst_cycles();

        // ADD, mem_ready tied high
        step(S_F, 1'b1, 1'b0, OP_ADD);
        step(S_D, 1'b1, 1'b0, OP_ADD);
        step(S_EX, 1'b1, 1'b0, OP_ADD);
        step(S_RWB, 1'b1, 1'b0, OP_ADD);

        // LOAD, mem_ready arrives on the 4th MEM_RD cycle
        step(S_F, 1'b1, 1'b0, OP_LD);
        step(S_D, 1'b1, 1'b0, OP_LD);
        step(S_MA, 1'b1, 1'b0, OP_LD);
        for (int i = 0; i < 3; i++) step(S_MRD, 1'b0, 1'b0, OP_LD);
        step(S_MRD, 1'b1, 1'b0, OP_LD);
        step(S_MWB, 1'b0, 1'b0, OP_LD);

        // BEQ taken, with one fetch wait cycle
        step(S_F, 1'b0, 1'b0, OP_BEQ);
        step(S_F, 1'b1, 1'b0, OP_BEQ);
        step(S_D, 1'b0, 1'b1, OP_BEQ);
        step(S_BR, 1'b1, 1'b1, OP_BEQ);

        // BEQ not taken
        step(S_F, 1'b1, 1'b0, OP_BEQ);
        step(S_D, 1'b0, 1'b0, OP_BEQ);
        step(S_BR, 1'b1, 1'b0, OP_BEQ);

        // JUMP
        step(S_F, 1'b1, 1'b0, OP_JMP);
        step(S_D, 1'b0, 1'b0, OP_JMP);
        step(S_J, 1'b0, 1'b0, OP_JMP);

        // STORE, mem_ready on the 15th wait cycle: success
        step(S_F, 1'b1, 1'b0, OP_ST);
        step(S_D, 1'b0, 1'b0, OP_ST);
        step(S_MA, 1'b0, 1'b0, OP_ST);
        for (int i = 0; i < 14; i++) step(S_MWR, 1'b0, 1'b0, OP_ST);
        step(S_MWR, 1'b1, 1'b0, OP_ST);

        // STORE, mem_ready never: timeout trap after 15 wait cycles
        step(S_F, 1'b1, 1'b0, OP_ST);
        step(S_D, 1'b0, 1'b0, OP_ST);
        step(S_MA, 1'b0, 1'b0, OP_ST);
        for (int i = 0; i < 15; i++) step(S_MWR, 1'b0, 1'b0, OP_ST);
        exp_cause = 2'b10;
        for (int i = 0; i < 3; i++) step(S_TRAP, 1'b1, 1'b1, OP_ST);
        rst_cycles();

        // Illegal opcode: trap held 20 cycles regardless of inputs
        step(S_F, 1'b1, 1'b0, OP_BAD);
        step(S_D, 1'b1, 1'b0, OP_BAD);
        exp_cause = 2'b01;
        for (int i = 0; i < 20; i++) begin
            logic [4:0] iv;
            iv = 5'(i);
            step(S_TRAP, iv[0], iv[1], iv[3:0]);
        end
        rst_cycles();

        // Async reset while a store is waiting
        step(S_F, 1'b1, 1'b0, OP_ST);
        step(S_D, 1'b0, 1'b0, OP_ST);
        step(S_MA, 1'b0, 1'b0, OP_ST);
        step(S_MWR, 1'b0, 1'b0, OP_ST);
        @(negedge clk);
        #2;
        check1("memwr_before_async_reset", int'(memwr), 1);
        rst_n = 1'b0;
        #1;
        check1("memwr_after_async_reset", int'(memwr), 0);
        check1("iord_after_async_reset", int'(iord), 0);
        check1("state_after_async_reset", int'(state), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cause = 2'b00;
        push_exp(S_IDLE, 1'b0, 1'b0);
        step(S_F, 1'b1, 1'b0, OP_ADD);
        step(S_D, 1'b1, 1'b0, OP_ADD);

        repeat (3) @(negedge clk);
        check1("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the 4-bit-opcode MIPS-style datapath.
- Replaces single-cycle opcode decoding with a state machine that steps each instruction through the phases it needs: fetch, decode, execute, memory and writeback.
- Drives PC/IR write enables, memory strobes, mux selects and ALU op.
- Waits on a memory ready handshake, with a timeout watchdog.

Parameters:
- TIMEOUT, 15: max cycles a memory strobe may wait for mem_ready; 0 disables the watchdog.
- TW, 4: width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  4  instruction opcode from IR, sampled in DECODE.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_wr  out  1  PC write enable.
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut register (branch target), 10 jump target.
- ir_wr  out  1  IR write enable.
- iord  out  1  memory address source: 0 PC, 1 ALUOut.
- memrd  out  1  memory read strobe.
- memwr  out  1  memory write strobe.
- memtoreg  out  1  register write data: 0 ALUOut, 1 MDR.
- regdes  out  1  destination register: 0 rt, 1 rd.
- regwr  out  1  register file write enable.
- alusrc_a  out  1  ALU A: 0 PC, 1 reg A.
- alusrc_b  out  2  ALU B: 00 reg B, 01 const 1, 10 sign-extended immediate, 11 sign-extended offset.
- aluop  out  2  00 add, 01 sub, 10 function by opcode.
- state  out  4  current state encoding, for debug.
- trap  out  1  sticky error flag.
- trap_cause  out  2  01 illegal opcode, 10 memory timeout.

Behaviour:
- Moore outputs, decoded combinationally from the registered state. Exceptions: ir_wr and pc_wr in FETCH, and pc_wr in BRANCH, also depend on inputs, as noted per state.
- Every output not listed for a state is 0.
- rst_n low: state=IDLE(0); trap=0; trap_cause=00; watchdog counter=0; all outputs 0.
- Reset is honoured mid-instruction and any memory access is abandoned.

State sequence:
- IDLE(0): all outputs 0 -> FETCH the next cycle. This is the first clock edge after reset release.
- FETCH(1): iord=0, memrd=1, alusrc_a=0, alusrc_b=01, aluop=00, pc_src=00.
  - Held until mem_ready=1.
  - In the mem_ready cycle, ir_wr=1 and pc_wr=1, then -> DECODE.
- DECODE(2): alusrc_a=0, alusrc_b=11, aluop=00 (branch target into ALUOut). Next state by opcode:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLT -> EXEC_R.
  - 0101 LOAD, 0110 STORE -> MEM_ADDR.
  - 0111 BEQ -> BRANCH.
  - 1000 JUMP -> JUMP.
  - 1001-1111 -> TRAP with cause 01.
- EXEC_R(3): alusrc_a=1, alusrc_b=00, aluop=10 -> R_WB.
- R_WB(4): regdes=1, memtoreg=0, regwr=1 -> FETCH.
- MEM_ADDR(5): alusrc_a=1, alusrc_b=10, aluop=00 -> MEM_RD for LOAD, MEM_WR for STORE. The opcode is held stable by the IR.
- MEM_RD(6): iord=1, memrd=1. Held until mem_ready=1, then -> MEM_WB.
- MEM_WB(7): regdes=0, memtoreg=1, regwr=1 -> FETCH.
- MEM_WR(8): iord=1, memwr=1. Held until mem_ready=1, then -> FETCH.
- BRANCH(9): alusrc_a=1, alusrc_b=00, aluop=01, pc_src=01, pc_wr=zero -> FETCH.
- JUMP(10): pc_src=10, pc_wr=1 -> FETCH.
- TRAP(15): all strobes 0, trap=1. Absorbing state; left only by reset.

Memory watchdog:
- The counter clears on entry to FETCH, MEM_RD and MEM_WR.
- It increments each cycle the state waits with mem_ready=0.
- If TIMEOUT!=0 and the counter reaches TIMEOUT while mem_ready is still 0 -> TRAP with cause 10.
- mem_ready=1 in the same cycle the counter reaches TIMEOUT counts as success and takes priority.

Other rules:
- mem_ready is ignored in all non-memory states.
- memrd and memwr are never both 1.
- regwr and pc_wr never assert in TRAP.
- Unused encodings 11-14 go to TRAP with cause 01 on the next edge.

Test Plan:
- ADD (0010), mem_ready tied 1 -> states 1,2,3,4,1.
  - ir_wr and pc_wr pulse 1 cycle in FETCH.
  - regwr=1 and regdes=1 only in R_WB.
  - 4 cycles per instruction.
- LOAD (0101), mem_ready delayed 3 cycles in MEM_RD -> MEM_RD held exactly 4 cycles with iord=1 and memrd=1.
  - Then MEM_WB with memtoreg=1, regwr=1, regdes=0.
- BEQ (0111) with zero=1 -> pc_wr=1 and pc_src=01 in BRANCH.
  - Repeat with zero=0 -> pc_wr stays 0.
  - Both return to FETCH.
- Opcode 1011 -> TRAP after DECODE with trap=1 and trap_cause=01.
  - Stays there 20 cycles regardless of inputs.
  - rst_n pulse low -> IDLE with all outputs 0.
- STORE with TIMEOUT=15 and mem_ready never asserted -> TRAP with cause 10 after 15 wait cycles.
  - Repeat with mem_ready on the 15th cycle -> FETCH, no trap.
- rst_n asserted asynchronously mid-MEM_WR -> memwr drops immediately without waiting for a clock edge.
  - After release: IDLE then FETCH.
